// File: rtl/axi_sha256_intr_v2.sv
// AXI4-Lite interrupt controller: per-source edge/level capture into ISR, enable mask,
// global enable and a combined level or fixed-width pulse interrupt request.
module axi_sha256_intr_v2 #(
    parameter int          C_NUM_OF_INTR       = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFFFFFF,
    parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFFFFFF,
    parameter int          C_IRQ_SENSITIVITY   = 0,
    parameter int          C_IRQ_ACTIVE_STATE  = 1,
    parameter int          C_IRQ_PULSE_CYCLES  = 4
) (
    input  logic                     S_AXI_INTR_ACLK,
    input  logic                     S_AXI_INTR_ARESET,
    input  logic [4:0]               S_AXI_INTR_AWADDR,
    input  logic                     S_AXI_INTR_AWVALID,
    output logic                     S_AXI_INTR_AWREADY,
    input  logic [31:0]              S_AXI_INTR_WDATA,
    input  logic [3:0]               S_AXI_INTR_WSTRB,
    input  logic                     S_AXI_INTR_WVALID,
    output logic                     S_AXI_INTR_WREADY,
    output logic [1:0]               S_AXI_INTR_BRESP,
    output logic                     S_AXI_INTR_BVALID,
    input  logic                     S_AXI_INTR_BREADY,
    input  logic [4:0]               S_AXI_INTR_ARADDR,
    input  logic                     S_AXI_INTR_ARVALID,
    output logic                     S_AXI_INTR_ARREADY,
    output logic [31:0]              S_AXI_INTR_RDATA,
    output logic [1:0]               S_AXI_INTR_RRESP,
    output logic                     S_AXI_INTR_RVALID,
    input  logic                     S_AXI_INTR_RREADY,
    input  logic [C_NUM_OF_INTR-1:0] intr_in,
    output logic                     irq
);

    localparam int         N          = C_NUM_OF_INTR;
    localparam logic       IRQ_ACTIVE = (C_IRQ_ACTIVE_STATE != 0);
    localparam logic [7:0] PULSE_LEN  = 8'(C_IRQ_PULSE_CYCLES);

    logic          aw_ready_reg;
    logic          b_valid_reg;
    logic          ar_ready_reg;
    logic          r_valid_reg;
    logic [31:0]   r_data_reg;
    logic          gie_reg;
    logic [N-1:0]  ier_reg;
    logic [N-1:0]  isr_reg;
    logic [N-1:0]  hist_reg;
    logic          armed_reg;

    logic          wr_fire;
    logic          rd_fire;
    logic [7:0]    wr_sel;
    logic [31:0]   wmask;
    logic [31:0]   wbits;
    logic [31:0]   rd_mux;
    logic [N-1:0]  act;
    logic [N-1:0]  evt;
    logic [N-1:0]  clr;
    logic [N-1:0]  set;
    logic [N-1:0]  isr_next;
    logic          cond;
    logic          irq_on;
    logic          unused_bits;

    assign wr_fire = aw_ready_reg & S_AXI_INTR_AWVALID & S_AXI_INTR_WVALID;
    assign rd_fire = ar_ready_reg & S_AXI_INTR_ARVALID;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{S_AXI_INTR_WSTRB[gi]}};
        end
        // History records "was active", so an edge only fires on an inactive-to-active
        // step, and the first cycle after reset merely primes it.
        for (gi = 0; gi < N; gi++) begin : g_src
            assign act[gi] = (intr_in[gi] == C_INTR_ACTIVE_STATE[gi]);
            if (C_INTR_SENSITIVITY[gi]) begin : g_edge
                assign evt[gi] = act[gi] & ~hist_reg[gi] & armed_reg;
            end else begin : g_level
                assign evt[gi] = act[gi];
            end
        end
    endgenerate

    assign wbits       = S_AXI_INTR_WDATA & wmask;
    assign unused_bits = &{1'b0, S_AXI_INTR_AWADDR[1:0], S_AXI_INTR_ARADDR[1:0], wbits};

    always_comb begin
        wr_sel = '0;
        if (wr_fire) wr_sel[S_AXI_INTR_AWADDR[4:2]] = 1'b1;
    end

    // Source events are OR-ed in after the clear, so a coincident set always wins.
    always_comb begin
        clr      = wr_sel[3] ? wbits[N-1:0] : '0;
        set      = wr_sel[5] ? wbits[N-1:0] : '0;
        isr_next = (isr_reg & ~clr) | set | evt;
    end

    always_comb begin
        rd_mux = '0;
        case (S_AXI_INTR_ARADDR[4:2])
            3'd0:    rd_mux[0]     = gie_reg;
            3'd1:    rd_mux[N-1:0] = ier_reg;
            3'd2:    rd_mux[N-1:0] = isr_reg;
            3'd4:    rd_mux[N-1:0] = isr_reg & ier_reg;
            default: rd_mux        = '0;
        endcase
    end

    always_ff @(posedge S_AXI_INTR_ACLK or posedge S_AXI_INTR_ARESET) begin
        if (S_AXI_INTR_ARESET) begin
            aw_ready_reg <= 1'b0;
            b_valid_reg  <= 1'b0;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_data_reg   <= '0;
        end else begin
            aw_ready_reg <= S_AXI_INTR_AWVALID & S_AXI_INTR_WVALID & ~b_valid_reg & ~aw_ready_reg;
            if (wr_fire)                b_valid_reg <= 1'b1;
            else if (S_AXI_INTR_BREADY) b_valid_reg <= 1'b0;
            ar_ready_reg <= S_AXI_INTR_ARVALID & ~r_valid_reg & ~ar_ready_reg;
            if (rd_fire) begin
                r_valid_reg <= 1'b1;
                r_data_reg  <= rd_mux;
            end else if (S_AXI_INTR_RREADY) begin
                r_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_INTR_ACLK or posedge S_AXI_INTR_ARESET) begin
        if (S_AXI_INTR_ARESET) begin
            gie_reg   <= 1'b0;
            ier_reg   <= '0;
            isr_reg   <= '0;
            hist_reg  <= '0;
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            hist_reg  <= act;
            isr_reg   <= isr_next;
            if (wr_sel[0] && S_AXI_INTR_WSTRB[0]) gie_reg <= S_AXI_INTR_WDATA[0];
            if (wr_sel[1]) ier_reg <= (ier_reg & ~wmask[N-1:0]) | wbits[N-1:0];
        end
    end

    assign cond = gie_reg & |(isr_reg & ier_reg);

    generate
        if (C_IRQ_SENSITIVITY == 0) begin : g_irq_level
            logic irq_on_reg;
            always_ff @(posedge S_AXI_INTR_ACLK or posedge S_AXI_INTR_ARESET) begin
                if (S_AXI_INTR_ARESET) irq_on_reg <= 1'b0;
                else                   irq_on_reg <= cond;
            end
            assign irq_on = irq_on_reg;
        end else begin : g_irq_pulse
            logic       cond_reg;
            logic [7:0] pulse_cnt_reg;
            // A rising condition only loads the counter when no pulse is running.
            always_ff @(posedge S_AXI_INTR_ACLK or posedge S_AXI_INTR_ARESET) begin
                if (S_AXI_INTR_ARESET) begin
                    cond_reg      <= 1'b0;
                    pulse_cnt_reg <= '0;
                end else begin
                    cond_reg <= cond;
                    if (pulse_cnt_reg != 8'd0)   pulse_cnt_reg <= pulse_cnt_reg - 8'd1;
                    else if (cond && !cond_reg) pulse_cnt_reg <= PULSE_LEN;
                end
            end
            assign irq_on = (pulse_cnt_reg != 8'd0);
        end
    endgenerate

    assign irq                = irq_on ? IRQ_ACTIVE : ~IRQ_ACTIVE;
    assign S_AXI_INTR_AWREADY = aw_ready_reg;
    assign S_AXI_INTR_WREADY  = aw_ready_reg;
    assign S_AXI_INTR_BVALID  = b_valid_reg;
    assign S_AXI_INTR_BRESP   = 2'b00;
    assign S_AXI_INTR_ARREADY = ar_ready_reg;
    assign S_AXI_INTR_RVALID  = r_valid_reg;
    assign S_AXI_INTR_RDATA   = r_data_reg;
    assign S_AXI_INTR_RRESP   = 2'b00;

endmodule

// File: tb/tb_axi_sha256_intr_v2.sv
// Bench for axi_sha256_intr_v2: dut0 (8 mixed sources, level irq) against a transaction-level
// model with random traffic, dut1 (4 edge sources, active-low pulse irq) with directed pulses.
module tb_axi_sha256_intr_v2;

    localparam logic [7:0] SENS0 = 8'h0F;   // bits 0-3 edge, 4-7 level
    localparam logic [7:0] ACT0  = 8'hCF;   // bits 4,5 active low

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic [1:0]  bresp  [2];
    logic [4:0]  araddr [2];
    logic [31:0] rdata  [2];
    logic [1:0]  rresp  [2];
    logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  arvalid, arready, rvalid, rready, irq;
    logic [7:0]  intr0;
    logic [3:0]  intr1;

    int          n_pass = 0;
    int          n_checks = 0;
    int          irq1_active = 0;

    logic        m_gie;
    logic [7:0]  m_ier, m_isr, m_prev, cur;

    always #5 clk = ~clk;
    always @(negedge clk) if (!irq[1]) irq1_active <= irq1_active + 1;

    axi_sha256_intr_v2 #(
        .C_NUM_OF_INTR(8), .C_INTR_SENSITIVITY(32'h0000000F), .C_INTR_ACTIVE_STATE(32'h000000CF),
        .C_IRQ_SENSITIVITY(0), .C_IRQ_ACTIVE_STATE(1), .C_IRQ_PULSE_CYCLES(4)
    ) dut0 (
        .S_AXI_INTR_ACLK(clk), .S_AXI_INTR_ARESET(rst),
        .S_AXI_INTR_AWADDR(awaddr[0]), .S_AXI_INTR_AWVALID(awvalid[0]), .S_AXI_INTR_AWREADY(awready[0]),
        .S_AXI_INTR_WDATA(wdata[0]), .S_AXI_INTR_WSTRB(wstrb[0]), .S_AXI_INTR_WVALID(wvalid[0]),
        .S_AXI_INTR_WREADY(wready[0]), .S_AXI_INTR_BRESP(bresp[0]), .S_AXI_INTR_BVALID(bvalid[0]),
        .S_AXI_INTR_BREADY(bready[0]), .S_AXI_INTR_ARADDR(araddr[0]), .S_AXI_INTR_ARVALID(arvalid[0]),
        .S_AXI_INTR_ARREADY(arready[0]), .S_AXI_INTR_RDATA(rdata[0]), .S_AXI_INTR_RRESP(rresp[0]),
        .S_AXI_INTR_RVALID(rvalid[0]), .S_AXI_INTR_RREADY(rready[0]), .intr_in(intr0), .irq(irq[0])
    );

    axi_sha256_intr_v2 #(
        .C_NUM_OF_INTR(4), .C_INTR_SENSITIVITY(32'hFFFFFFFF), .C_INTR_ACTIVE_STATE(32'hFFFFFFFF),
        .C_IRQ_SENSITIVITY(1), .C_IRQ_ACTIVE_STATE(0), .C_IRQ_PULSE_CYCLES(4)
    ) dut1 (
        .S_AXI_INTR_ACLK(clk), .S_AXI_INTR_ARESET(rst),
        .S_AXI_INTR_AWADDR(awaddr[1]), .S_AXI_INTR_AWVALID(awvalid[1]), .S_AXI_INTR_AWREADY(awready[1]),
        .S_AXI_INTR_WDATA(wdata[1]), .S_AXI_INTR_WSTRB(wstrb[1]), .S_AXI_INTR_WVALID(wvalid[1]),
        .S_AXI_INTR_WREADY(wready[1]), .S_AXI_INTR_BRESP(bresp[1]), .S_AXI_INTR_BVALID(bvalid[1]),
        .S_AXI_INTR_BREADY(bready[1]), .S_AXI_INTR_ARADDR(araddr[1]), .S_AXI_INTR_ARVALID(arvalid[1]),
        .S_AXI_INTR_ARREADY(arready[1]), .S_AXI_INTR_RDATA(rdata[1]), .S_AXI_INTR_RRESP(rresp[1]),
        .S_AXI_INTR_RVALID(rvalid[1]), .S_AXI_INTR_RREADY(rready[1]), .intr_in(intr1), .irq(irq[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model of dut0 ----------------
    function automatic logic [7:0] act_of(input logic [7:0] v);
        return ~(v ^ ACT0);
    endfunction

    task automatic m_apply_intr(input logic [7:0] v);
        logic [7:0] a;
        a      = act_of(v);
        m_isr  = m_isr | (a & ~m_prev & SENS0) | (a & ~SENS0);
        m_prev = a;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        case (addr)
            5'h00:   return {31'b0, m_gie};
            5'h04:   return {24'b0, m_ier};
            5'h08:   return {24'b0, m_isr};
            5'h10:   return {24'b0, m_isr & m_ier};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_gie & (|(m_isr & m_ier));
    endfunction

    // ---------------- bus tasks ----------------
    task automatic axi_write(input int d, input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] intr_hs);
        @(negedge clk);
        awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
        awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (awready[d]) break;
        end
        if (!awready[d]) check("aw_timeout", 32'(awready[d]), 32'd1);
        check("wready_with_awready", 32'(wready[d]), 32'd1);
        if (d == 0) intr0 = intr_hs;
        @(posedge clk); #1;
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        check("bvalid", 32'(bvalid[d]), 32'd1);
        check("bresp", 32'(bresp[d]), 32'd0);
        bready[d] = 1'b1;
        @(posedge clk); #1;
        bready[d] = 1'b0;
        check("bvalid_drop", 32'(bvalid[d]), 32'd0);
        $display("wr dut%0d addr=%h data=%h strb=%h", d, addr, data, strb);
    endtask

    task automatic axi_read(input int d, input logic [4:0] addr, output logic [31:0] data);
        @(negedge clk);
        araddr[d] = addr; arvalid[d] = 1'b1; rready[d] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (arready[d]) break;
        end
        if (!arready[d]) check("ar_timeout", 32'(arready[d]), 32'd1);
        @(posedge clk); #1;
        arvalid[d] = 1'b0;
        check("rvalid", 32'(rvalid[d]), 32'd1);
        check("rresp", 32'(rresp[d]), 32'd0);
        data = rdata[d];
        rready[d] = 1'b1;
        @(posedge clk); #1;
        rready[d] = 1'b0;
        check("rvalid_drop", 32'(rvalid[d]), 32'd0);
        $display("rd dut%0d addr=%h data=%h", d, addr, data);
    endtask

    task automatic wr0(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input logic [7:0] nv);
        logic [31:0] bm, dm;
        logic [7:0]  clr, set;
        axi_write(0, addr, data, strb, nv);
        bm  = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        dm  = data & bm;
        clr = '0; set = '0;
        case (addr)
            5'h00: if (strb[0]) m_gie = data[0];
            5'h04: m_ier = (m_ier & ~bm[7:0]) | dm[7:0];
            5'h0C: clr = dm[7:0];
            5'h14: set = dm[7:0];
            default: ;
        endcase
        m_isr = (m_isr & ~clr) | set;
        m_apply_intr(nv);
        cur = nv;
        check("irq_after_wr", 32'(irq[0]), 32'(m_irq()));
    endtask

    task automatic rd0(input logic [4:0] addr);
        logic [31:0] v;
        axi_read(0, addr, v);
        check($sformatf("rd_%02h", addr), v, m_read(addr));
        check("irq_after_rd", 32'(irq[0]), 32'(m_irq()));
    endtask

    task automatic set_intr(input logic [7:0] v);
        @(posedge clk); #1;
        intr0 = v; cur = v;
        m_apply_intr(v);
        repeat (2) @(posedge clk);
        #1;
        check("irq_after_intr", 32'(irq[0]), 32'(m_irq()));
    endtask

    task automatic model_reset();
        m_gie = 1'b0; m_ier = '0; m_isr = '0;
        m_prev = act_of(intr0);   // already-active sources give no edge at release
        cur = intr0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          c0;
        logic [4:0]  addr;
        logic [7:0]  nv;
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; wdata[i] = '0; wstrb[i] = '0; araddr[i] = '0;
        end
        awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
        intr0 = 8'h30; intr1 = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata0", rdata[0], 32'd0);
        check("rst_rdata1", rdata[1], 32'd0);
        check("rst_irq", 32'(irq), 32'h2);
        @(negedge clk); rst = 1'b0;
        model_reset();

        // edge on source 0 reaches irq two cycles later; IAR clears it
        wr0(5'h00, 32'h1, 4'hF, cur);
        wr0(5'h04, 32'h1, 4'hF, cur);
        @(posedge clk); #1;
        intr0 = 8'h31; cur = 8'h31; m_apply_intr(cur);
        @(posedge clk); #1;
        check("irq_lat1", 32'(irq[0]), 32'd0);
        @(posedge clk); #1;
        check("irq_lat2", 32'(irq[0]), 32'd1);
        rd0(5'h10);
        wr0(5'h0C, 32'h1, 4'hF, cur);
        rd0(5'h10);

        // level sources stay set while held, even across an IAR
        wr0(5'h0C, 32'hFF, 4'hF, 8'h30);
        set_intr(8'hB1);
        rd0(5'h08);
        rd0(5'h10);
        wr0(5'h0C, 32'h80, 4'hF, cur);
        rd0(5'h08);

        // edge event and IAR on the same bit in the same cycle
        wr0(5'h0C, 32'h02, 4'hF, cur | 8'h02);
        axi_read(0, 5'h08, v);
        check("edge_beats_iar", v & 32'h2, 32'h2);

        // unmapped read and zero-strobe write
        rd0(5'h18);
        wr0(5'h04, 32'hFFFFFFFF, 4'h0, cur);
        rd0(5'h04);

        // randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            addr = 5'($urandom_range(0, 7) * 4);
            nv   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : cur;
            if ($urandom_range(0, 2) == 0) rd0(addr);
            else wr0(addr, $urandom, 4'($urandom_range(0, 15)), nv);
        end

        // reset with a write response pending
        wr0(5'h00, 32'h1, 4'hF, cur);
        wr0(5'h04, 32'hFF, 4'hF, cur);
        wr0(5'h14, 32'hFF, 4'hF, cur);
        @(negedge clk);
        awaddr[0] = 5'h04; wdata[0] = 32'h5A; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (awready[0]) break;
        end
        @(posedge clk); #1;
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        check("b_pending", 32'(bvalid[0]), 32'd1);
        @(posedge clk); #1;
        check("b_hold", 32'(bvalid[0]), 32'd1);
        intr0 = 8'h31;
        rst = 1'b1;
        #1;
        check("rst_mid_bvalid", 32'(bvalid[0]), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'h2);
        check("rst_mid_rdata", rdata[0], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_reset();
        $display("reset released with intr0=%h", intr0);
        rd0(5'h00);
        rd0(5'h04);
        rd0(5'h08);
        set_intr(8'h30);
        set_intr(8'h31);
        rd0(5'h08);

        // pulse irq on dut1: exactly four active cycles, no extension
        axi_write(1, 5'h00, 32'h1, 4'hF, cur);
        axi_write(1, 5'h04, 32'hF, 4'hF, cur);
        c0 = irq1_active;
        axi_write(1, 5'h14, 32'h1, 4'hF, cur);
        axi_write(1, 5'h14, 32'h2, 4'hF, cur);
        repeat (10) @(posedge clk);
        #1;
        check("pulse_width", 32'(irq1_active - c0), 32'd4);
        check("pulse_idle", 32'(irq[1]), 32'd1);
        axi_write(1, 5'h0C, 32'hF, 4'hF, cur);
        c0 = irq1_active;
        axi_write(1, 5'h14, 32'h4, 4'hF, cur);
        repeat (10) @(posedge clk);
        #1;
        check("pulse_again", 32'(irq1_active - c0), 32'd4);
        axi_write(1, 5'h0C, 32'hF, 4'hF, cur);
        c0 = irq1_active;
        @(posedge clk); #1;
        intr1 = 4'h8;
        repeat (10) @(posedge clk);
        #1;
        check("pulse_from_edge", 32'(irq1_active - c0), 32'd4);
        axi_read(1, 5'h08, v);
        check("dut1_isr", v, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
